imem_arbiter: RTL
=================

# imem_arbiter

Two-port read arbiter and burst sequencer for the single combinational read port of the instruction memory (text segment). It shares that port between the instruction-fetch requester (port 0) and a debug/monitor requester (port 1). Each accepted request is a burst of 1–4 consecutive words, which the arbiter issues one word per cycle. Read data is registered and returned with per-port valid and last flags. The block sits between the fetch stage / debug monitor and `imem`.

## Interface
Parameters:
- `n`, default 32: word width, matching `imem`.
- `r`, default 6: address width; `imem` depth is 2**r words.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req0` in 1: port 0 (fetch) request. Held until `gnt0` is seen.
- `addr0` in r: port 0 burst base word address. Held with `req0`.
- `len0` in 2: port 0 burst length minus one (0 = 1 word, 3 = 4 words). Held with `req0`.
- `gnt0` out 1: combinational one-cycle pulse; the port 0 request is accepted this cycle.
- `rvalid0` out 1: `rdata` holds a port 0 word this cycle.
- `rlast0` out 1: qualifies the final word of a port 0 burst.
- `req1`, `addr1`, `len1`, `gnt1`, `rvalid1`, `rlast1`: port 1 (debug), same widths and rules as port 0.
- `rdata` out n: registered read data, shared by both ports.
- `imem_addr` out r: drives `imem.addr`.
- `imem_read_dat` in n: from `imem.read_dat`.
- `busy` out 1: high while in BURST.

## Operation
- FSM states:
  - IDLE: arbitration is allowed.
  - BURST: words 1..len are being issued; no arbitration.
- IDLE with no request:
  - `imem_addr` = 0.
  - No grant.
- IDLE with one or both requests:
  - Select the winner p and pulse `gnt_p`.
  - Drive `imem_addr` = `addr_p`; this issues word 0.
  - Capture base, len and port into registers; load beat counter = 1.
  - If `len_p` = 0, stay in IDLE; otherwise go to BURST.
- BURST:
  - `imem_addr` = (base + beat) mod 2**r. Address wraps from 2**r−1 to 0 inside a burst.
  - Beat counter increments each cycle.
  - The cycle issuing beat == len is the last BURST cycle; the next state is IDLE.
- Response path:
  - Every issued word is captured into `rdata` at the end of its issue cycle.
  - `rvalid_p` is asserted the following cycle.
  - `rlast_p` accompanies the word for beat == len.
  - In cycles with no response, `rdata` holds its last value and `rvalid0`/`rvalid1` are 0.
- Arbitration policy is set by the macro (see Configuration).
- A request arriving in a BURST cycle waits. `req` deasserted before grant withdraws the request; no state is left behind.
- Address and length sampled at the grant are used for the whole burst. Input changes after the grant are ignored.
- Reset (asynchronous, at any time, including mid-burst):
  - State = IDLE; beat counter and base = 0.
  - `rdata` = 0; `rvalid*` = 0; `rlast*` = 0; `busy` = 0.
  - `gnt*` is forced to 0 while `reset` is high.
  - Aborted bursts produce no further responses.
  - The round-robin pointer resets to favour port 0.

## Timing
- Grant at cycle T issues word 0 at T. Word k issues at T+k; its response arrives at T+k+1.
- Read latency is 1 cycle from the issue cycle to `rvalid`.
- A burst of len+1 words occupies issue cycles T..T+len. The next grant is possible at T+len+1.
- Single-word (len=0) requests can therefore be granted every cycle, at full throughput.
- Responses are in order and never interleaved between ports. `rvalid0` and `rvalid1` are never high together.
- `gnt_p` and `imem_addr` in IDLE are combinational from `req`/`addr`. There is no combinational path from `imem_read_dat` to any output.

## Configuration
- `IMEM_ARB_RR_EN` defined: round-robin arbitration.
  - When both ports request in IDLE, the winner is the port not granted most recently.
  - A pointer register updates on every grant.
- `IMEM_ARB_RR_EN` undefined: fixed priority.
  - Port 0 always wins; port 1 is granted only when `req0` = 0.
  - The pointer register is not built.

## Test plan
- Single read: `imem` preloaded with RAM[i] = 32'h1000_0000+i; `req0`, `addr0`=5, `len0`=0 at T → `gnt0` at T; at T+1 `rvalid0`=`rlast0`=1 with `rdata`=32'h1000_0005; `busy` stays 0.
- Wrapping burst: `req1`, `addr1`=62, `len1`=3 → `imem_addr` 62, 63, 0, 1 over T..T+3; `rvalid1` at T+1..T+4 with data ...003E, ...003F, ...0000, ...0001; `rlast1` only at T+4; `busy` high T+1..T+3.
- Contention: both ports hold `len`=0 requests for 4 cycles, addresses 2 and 9.
  - With `IMEM_ARB_RR_EN`: grants alternate 0,1,0,1.
  - Without it: `gnt0` on all 4 cycles and `gnt1` never.
- Back-to-back: port 0 burst len=1 granted at T; `req1` waiting from T+1 → `gnt1` exactly at T+2, no gap in `rvalid` between bursts.
- Reset mid-burst: `len0`=3 granted at T; `reset` pulsed at T+2 (asynchronously) → all outputs 0 immediately; no further `rvalid0`; a new `req1` after reset release is granted on its first cycle.
- Withdrawn request: `req1` raised during a port 0 burst and dropped before it ends → `gnt1` never pulses; FSM returns to IDLE with `imem_addr`=0.

Source files
------------

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
//
// Shares the single combinational read port of the instruction memory between
// the fetch requester (port 0) and the debug/monitor requester (port 1).
// Each grant starts a burst of 1..4 consecutive words, one word per cycle.
// Read data is registered and returned one cycle after its issue cycle, with
// per-port valid/last flags.
//
// Build option:
//   IMEM_ARB_RR_EN  defined   -> round-robin arbitration between the ports
//                   undefined -> fixed priority, port 0 always wins
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req0/addr0/len0     port 0 request, burst base address, length-1
//   gnt0                port 0 accepted this cycle (combinational pulse)
//   rvalid0/rlast0      port 0 response valid / final word of burst
//   req1 .. rlast1      same for port 1
//   rdata               registered read data shared by both ports
//   imem_addr           address to imem
//   imem_read_dat       data from imem
//   busy                high while words 1..len of a burst are being issued
// ---------------------------------------------------------------------------
module imem_arbiter #(
    parameter int n = 32,
    parameter int r = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [r-1:0] addr0,
    input  logic [1:0]   len0,
    output logic         gnt0,
    output logic         rvalid0,
    output logic         rlast0,
    input  logic         req1,
    input  logic [r-1:0] addr1,
    input  logic [1:0]   len1,
    output logic         gnt1,
    output logic         rvalid1,
    output logic         rlast1,
    output logic [n-1:0] rdata,
    output logic [r-1:0] imem_addr,
    input  logic [n-1:0] imem_read_dat,
    output logic         busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t       state_reg, state_next;
    logic [r-1:0] base_reg, base_next;
    logic [1:0]   len_reg, len_next;
    logic [1:0]   beat_reg, beat_next;
    logic         port_reg, port_next;

    // Word issued this cycle and where its response goes.
    logic         issue_valid;
    logic         issue_port;
    logic         issue_last;

    logic         win;          // selected port when any request is present
    logic [r-1:0] sel_addr;
    logic [1:0]   sel_len;

    logic [n-1:0] rdata_reg;
    logic [1:0]   rvalid_reg;
    logic [1:0]   rlast_reg;

`ifdef IMEM_ARB_RR_EN
    // rr_reg = 1 means port 1 has priority on the next contended cycle.
    logic rr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_reg <= 1'b0;
        end else if (gnt0 || gnt1) begin
            rr_reg <= gnt0;
        end
    end

    assign win = (req0 && req1) ? rr_reg : req1;
`else
    assign win = ~req0;
`endif

    assign sel_addr = win ? addr1 : addr0;
    assign sel_len  = win ? len1  : len0;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            base_reg  <= '0;
            len_reg   <= '0;
            beat_reg  <= '0;
            port_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            len_reg   <= len_next;
            beat_reg  <= beat_next;
            port_reg  <= port_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, grant and issue logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        base_next   = base_reg;
        len_next    = len_reg;
        beat_next   = beat_reg;
        port_next   = port_reg;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        imem_addr   = '0;
        issue_valid = 1'b0;
        issue_port  = port_reg;
        issue_last  = 1'b0;

        case (state_reg)
            IDLE: begin
                // Reset gates the grant so nothing is accepted while held.
                if (!reset && (req0 || req1)) begin
                    gnt0        = ~win;
                    gnt1        = win;
                    imem_addr   = sel_addr;
                    issue_valid = 1'b1;
                    issue_port  = win;
                    issue_last  = (sel_len == 2'd0);
                    base_next   = sel_addr;
                    len_next    = sel_len;
                    port_next   = win;
                    beat_next   = 2'd1;
                    if (sel_len != 2'd0) begin
                        state_next = BURST;
                    end
                end
            end
            BURST: begin
                // Natural r-bit overflow gives the wrap from top of memory to 0.
                imem_addr   = base_reg + {{(r-2){1'b0}}, beat_reg};
                issue_valid = 1'b1;
                issue_last  = (beat_reg == len_reg);
                beat_next   = beat_reg + 2'd1;
                if (beat_reg == len_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response path: capture the issued word, flag it for its port next cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_reg <= '0;
        end else if (issue_valid) begin
            rdata_reg <= imem_read_dat;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rvalid_reg[gi] <= 1'b0;
                    rlast_reg[gi]  <= 1'b0;
                end else begin
                    rvalid_reg[gi] <= issue_valid && (issue_port == 1'(gi));
                    rlast_reg[gi]  <= issue_valid && (issue_port == 1'(gi)) && issue_last;
                end
            end
        end
    endgenerate

    assign rdata   = rdata_reg;
    assign rvalid0 = rvalid_reg[0];
    assign rvalid1 = rvalid_reg[1];
    assign rlast0  = rlast_reg[0];
    assign rlast1  = rlast_reg[1];
    assign busy    = (state_reg == BURST);

endmodule
